tdr_access_sequencer: RTL and testbench

- Autonomous IJTAG access controller for the counter-control TDR (5-bit, LSB-first, capture/shift/update).
- Accepts one read-modify-write request per transaction from a local host (test FSM / debug master).
- Generates the sel/ce/se/ue/si sequence on ijtag_tck, collects ijtag_so, and returns captured data.
- Sits between the host and the TDR's ijtag_* pins, replacing a full TAP/SIB path for on-chip self-test of the counter.

---
 rtl/tdr_access_sequencer_if.sv | 59 +++++
 rtl/tdr_access_sequencer.sv | 131 +++++++++++++
 tb/tb_tdr_access_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/tdr_access_sequencer_if.sv
// ---------------------------------------------------------------------------
// tdr_access_sequencer_if
//
// Purpose: bundles the host request/response handshake and the IJTAG pins of
// the counter-control TDR into one interface. The sequencer connects through
// the slave modport. A host or testbench that drives requests and plays the
// TDR side uses the master modport.
//
// Optional macro: TDR_SEQ_NO_CAPTURE_EN adds req_no_capture.
//
// Signals:
//   req_valid / req_ready / req_wdata   host request handshake and write word
//   rsp_valid / rsp_ready / rsp_rdata   response handshake and captured word
//   busy                                sequencer not idle
//   ijtag_sel/ce/se/ue/si               drive to the TDR
//   ijtag_so                            serial data back from the TDR
//   req_no_capture                      (macro only) skip the capture phase
// ---------------------------------------------------------------------------
interface tdr_access_sequencer_if #(
  parameter int LEN = 5
);
  logic           req_valid;
  logic           req_ready;
  logic [LEN-1:0] req_wdata;
`ifdef TDR_SEQ_NO_CAPTURE_EN
  logic           req_no_capture;
`endif
  logic           rsp_valid;
  logic           rsp_ready;
  logic [LEN-1:0] rsp_rdata;
  logic           busy;
  logic           ijtag_sel;
  logic           ijtag_ce;
  logic           ijtag_se;
  logic           ijtag_ue;
  logic           ijtag_si;
  logic           ijtag_so;

  // The sequencer consumes requests and the TDR serial output, and drives
  // everything else.
  modport slave (
    input  req_valid, req_wdata, rsp_ready, ijtag_so,
`ifdef TDR_SEQ_NO_CAPTURE_EN
    input  req_no_capture,
`endif
    output req_ready, rsp_valid, rsp_rdata, busy,
    output ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si
  );

  // The host, or a testbench standing in for host plus TDR, is the mirror image.
  modport master (
    output req_valid, req_wdata, rsp_ready, ijtag_so,
`ifdef TDR_SEQ_NO_CAPTURE_EN
    output req_no_capture,
`endif
    input  req_ready, rsp_valid, rsp_rdata, busy,
    input  ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si
  );
endinterface

// File: rtl/tdr_access_sequencer.sv
// ---------------------------------------------------------------------------
// tdr_access_sequencer
//
// Purpose: self-contained IJTAG access controller for the 5-bit counter
// control TDR. It takes one read-modify-write request from the host and
// walks the TDR through capture, shift (LSB first) and update. It collects
// the shifted-out bits and returns them as the response.
//
// Optional macro: TDR_SEQ_NO_CAPTURE_EN. When defined, req_no_capture=1
// skips the capture phase, so the response carries the TDR's previous shift
// contents. This supports write-verify.
//
// Ports:
//   ijtag_tck    scan clock; all state changes on its rising edge
//   ijtag_reset  asynchronous, active-high reset
//   bus          tdr_access_sequencer_if.slave
//                (host request/response and TDR ijtag_* pins)
// ---------------------------------------------------------------------------
module tdr_access_sequencer #(
  parameter int LEN   = 5,
  parameter int CNT_W = $clog2(LEN)
) (
  input  logic                   ijtag_tck,
  input  logic                   ijtag_reset,
  tdr_access_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SHIFT,
    UPDATE,
    RESP
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN-1:0]   wdata_q, wdata_d;
  logic [LEN-1:0]   rdata_q, rdata_d;

  // State register. Reset forces IDLE at once, so every ijtag_* control
  // drops asynchronously and an aborted scan never reaches update.
  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state and Moore outputs. Every ijtag_* output and req_ready decode
  // only from registered state, so no combinational path runs from the host
  // request to the TDR pins. In SHIFT, each rising edge both samples so into
  // bit cnt and moves to the next bit. The retimed so is therefore bit cnt of
  // the TDR contents.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.ijtag_sel = 1'b0;
    bus.ijtag_ce  = 1'b0;
    bus.ijtag_se  = 1'b0;
    bus.ijtag_ue  = 1'b0;
    bus.ijtag_si  = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          wdata_d = bus.req_wdata;
          rdata_d = '0;
          cnt_d   = '0;
`ifdef TDR_SEQ_NO_CAPTURE_EN
          state_d = bus.req_no_capture ? SHIFT : CAPTURE;
`else
          state_d = CAPTURE;
`endif
        end
      end
      CAPTURE: begin
        bus.ijtag_sel = 1'b1;
        bus.ijtag_ce  = 1'b1;
        cnt_d         = '0;
        state_d       = SHIFT;
      end
      SHIFT: begin
        bus.ijtag_sel  = 1'b1;
        bus.ijtag_se   = 1'b1;
        bus.ijtag_si   = wdata_q[cnt_q];
        rdata_d[cnt_q] = bus.ijtag_so;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = UPDATE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      UPDATE: begin
        bus.ijtag_sel = 1'b1;
        bus.ijtag_ue  = 1'b1;
        state_d       = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Response word and busy flag come straight from registered state.
  always_comb begin
    bus.rsp_rdata = rdata_q;
    bus.busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_tdr_access_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tdr_access_sequencer
//
// Purpose: directed test of tdr_access_sequencer against a small behavioural
// model of the counter-control TDR. The model's led inputs are held at
// 4'b1010.
//
// TDR update bit map: {mux_sel, fi_en, nRst, backward, cnt} = bits [4:0].
// Optional macro: TDR_SEQ_NO_CAPTURE_EN enables the write-verify section.
// ---------------------------------------------------------------------------
module tb_tdr_access_sequencer;

  localparam int LEN = 5;

  logic ijtagTck   = 1'b0;
  logic ijtagReset = 1'b1;

  tdr_access_sequencer_if #(.LEN(LEN)) bus ();

  tdr_access_sequencer #(.LEN(LEN)) dut (
    .ijtag_tck   (ijtagTck),
    .ijtag_reset (ijtagReset),
    .bus         (bus.slave)
  );

  // Free-running scan clock with a 10-unit period.
  initial forever #5 ijtagTck = ~ijtagTck;

  // Behavioural counter-control TDR. Capture loads {0, led}. Shift moves
  // right with si entering at the MSB, so the first bit shifted ends up in
  // bit 0. so is retimed on the falling edge. Update latches on the falling
  // edge. The model ignores the sequencer reset, so aborted scans leave the
  // update register unchanged.
  logic [3:0]     led       = 4'b1010;
  logic [LEN-1:0] tdrShift  = '0;
  logic [LEN-1:0] tdrUpdate = '0;
  logic           tdrSoQ    = 1'b0;
  int             ueCount   = 0;

  assign bus.ijtag_so = tdrSoQ;

  // Capture or shift on the rising edge, as the TDR does.
  always @(posedge ijtagTck) begin
    if (bus.ijtag_sel && bus.ijtag_ce)
      tdrShift <= {1'b0, led};
    else if (bus.ijtag_sel && bus.ijtag_se)
      tdrShift <= {bus.ijtag_si, tdrShift[LEN-1:1]};
  end

  // Retime so and latch update on the falling edge.
  always @(negedge ijtagTck) begin
    tdrSoQ <= tdrShift[0];
    if (bus.ijtag_sel && bus.ijtag_ue)
      tdrUpdate <= tdrShift;
  end

  // Count every ue pulse, so an aborted scan can be shown to have none.
  always @(posedge bus.ijtag_ue) ueCount <= ueCount + 1;

  int compareCount  = 0;
  int mismatchCount = 0;

  // Single comparison point. Every check is counted here, and any mismatch
  // is reported here.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Advance one rising edge, then settle 1 unit past it before sampling.
  task automatic tick();
    @(posedge ijtagTck);
    #1;
  endtask

  // Present a request while the sequencer is idle, and drop it after the
  // accepting edge.
  task automatic applyStimulus(input logic [LEN-1:0] wdata, input logic noCapture);
    bus.req_valid = 1'b1;
    bus.req_wdata = wdata;
`ifdef TDR_SEQ_NO_CAPTURE_EN
    bus.req_no_capture = noCapture;
`else
    if (noCapture) $display("[TB] no-capture request ignored in this build");
`endif
    tick();
    bus.req_valid = 1'b0;
  endtask

  function automatic logic [3:0] ctrl();
    return {bus.ijtag_sel, bus.ijtag_ce, bus.ijtag_se, bus.ijtag_ue};
  endfunction

  // Main directed sequence.
  initial begin
    logic [LEN-1:0] w;
    int gap;
    int ueBefore;
    bit seenResp;

    bus.req_valid = 1'b0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
`ifdef TDR_SEQ_NO_CAPTURE_EN
    bus.req_no_capture = 1'b0;
`endif

    // Reset state: checked while reset is held, and again after release.
    #12;
    checkOutput("reset_ctrl", {28'd0, ctrl()}, 32'h0);
    checkOutput("reset_si", {31'd0, bus.ijtag_si}, 32'h0);
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'h0);
    ijtagReset = 1'b0;
    #1;
    checkOutput("rel_req_ready", {31'd0, bus.req_ready}, 32'h1);
    checkOutput("rel_rsp_valid", {31'd0, bus.rsp_valid}, 32'h0);
    checkOutput("rel_rsp_rdata", {27'd0, bus.rsp_rdata}, 32'h0);

    // Transaction 1: write 10110 with led=1010.
    w = 5'b10110;
    applyStimulus(w, 1'b0);
    checkOutput("t1_capture_ctrl", {28'd0, ctrl()}, 32'hC);
    checkOutput("t1_busy", {31'd0, bus.busy}, 32'h1);
    checkOutput("t1_req_ready", {31'd0, bus.req_ready}, 32'h0);
    for (int k = 0; k < LEN; k++) begin
      tick();
      checkOutput($sformatf("t1_shift%0d_ctrl", k), {28'd0, ctrl()}, 32'hA);
      checkOutput($sformatf("t1_shift%0d_si", k), {31'd0, bus.ijtag_si}, {31'd0, w[k]});
    end
    tick();
    checkOutput("t1_update_ctrl", {28'd0, ctrl()}, 32'h9);
    tick();
    checkOutput("t1_rsp_valid", {31'd0, bus.rsp_valid}, 32'h1);
    checkOutput("t1_rsp_rdata", {27'd0, bus.rsp_rdata}, 32'h0A);
    checkOutput("t1_resp_ctrl", {28'd0, ctrl()}, 32'h0);
    checkOutput("t1_tdr_update", {27'd0, tdrUpdate}, 32'h16);

    // Hold rsp_ready low for 10 cycles while a second request waits.
    bus.req_valid = 1'b1;
    bus.req_wdata = 5'b00100;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("hold%0d_rsp_valid", i), {31'd0, bus.rsp_valid}, 32'h1);
      checkOutput($sformatf("hold%0d_rdata", i), {27'd0, bus.rsp_rdata}, 32'h0A);
      checkOutput($sformatf("hold%0d_req_ready", i), {31'd0, bus.req_ready}, 32'h0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    checkOutput("hs_rsp_valid", {31'd0, bus.rsp_valid}, 32'h0);
    checkOutput("hs_req_ready", {31'd0, bus.req_ready}, 32'h1);
    tick();
    checkOutput("b2b1_capture_ctrl", {28'd0, ctrl()}, 32'hC);

    // Back-to-back requests: 00100 is in CAPTURE now and 11111 waits.
    bus.req_wdata = 5'b11111;
    gap = 0;
    seenResp = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bus.rsp_valid && !seenResp) begin
        seenResp = 1'b1;
        checkOutput("b2b1_tdr_update", {27'd0, tdrUpdate}, 32'h04);
        checkOutput("b2b1_rdata", {27'd0, bus.rsp_rdata}, 32'h0A);
      end
      if (bus.ijtag_ce) begin
        gap = i;
        break;
      end
    end
    bus.req_valid = 1'b0;
    checkOutput("b2b_gap", gap, LEN + 4);
    for (int i = 0; i < LEN + 2; i++) tick();
    checkOutput("b2b2_rsp_valid", {31'd0, bus.rsp_valid}, 32'h1);
    checkOutput("b2b2_rdata", {27'd0, bus.rsp_rdata}, 32'h0A);
    checkOutput("b2b2_tdr_update", {27'd0, tdrUpdate}, 32'h1F);
    tick();
    checkOutput("b2b2_idle", {31'd0, bus.req_ready}, 32'h1);

    // Reset asserted during SHIFT with cnt=2.
    applyStimulus(5'b00100, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("rst_pre_ctrl", {28'd0, ctrl()}, 32'hA);
    checkOutput("rst_pre_si", {31'd0, bus.ijtag_si}, 32'h1);
    ueBefore = ueCount;
    #2 ijtagReset = 1'b1;
    #1;
    checkOutput("rst_mid_ctrl", {28'd0, ctrl()}, 32'h0);
    checkOutput("rst_mid_si", {31'd0, bus.ijtag_si}, 32'h0);
    tick();
    ijtagReset = 1'b0;
    tick();
    checkOutput("rst_ue_count", ueCount, ueBefore);
    checkOutput("rst_tdr_kept", {27'd0, tdrUpdate}, 32'h1F);
    checkOutput("rst_req_ready", {31'd0, bus.req_ready}, 32'h1);
    checkOutput("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'h0);

`ifdef TDR_SEQ_NO_CAPTURE_EN
    // Write-verify: write 10011, then shift zeros without capture.
    applyStimulus(5'b10011, 1'b0);
    for (int i = 0; i < LEN + 2; i++) tick();
    checkOutput("nc_write_valid", {31'd0, bus.rsp_valid}, 32'h1);
    tick();
    applyStimulus(5'b00000, 1'b1);
    checkOutput("nc_first_ctrl", {28'd0, ctrl()}, 32'hA);
    for (int i = 0; i < LEN; i++) begin
      tick();
      checkOutput($sformatf("nc_ce%0d", i), {31'd0, bus.ijtag_ce}, 32'h0);
    end
    tick();
    checkOutput("nc_rsp_valid", {31'd0, bus.rsp_valid}, 32'h1);
    checkOutput("nc_rdata", {27'd0, bus.rsp_rdata}, 32'h13);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
